// File: rtl/mem_wb_pkg.sv
// Shared constants, FSM state type and opcode helpers for the MEM/WB stage.
package mem_wb_pkg;

  localparam logic [5:0]  OP_RTYPE    = 6'b000000;
  localparam logic [5:0]  OP_LW       = 6'b100011;
  localparam logic [5:0]  OP_SW       = 6'b101011;
  localparam logic [31:0] FINISH_WORD = 32'hFFFF_FFFF;

  // addi, addiu, slti, sltiu, andi, ori, xori, lui
  localparam logic [5:0] ALU_IMM_OPS [8] = '{
    6'b001000, 6'b001001, 6'b001010, 6'b001011,
    6'b001100, 6'b001101, 6'b001110, 6'b001111
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2,
    HALT = 2'd3
  } state_t;

  function automatic logic is_alu_imm(input logic [5:0] op);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (op == ALU_IMM_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/mem_wb_decode.sv
// Combinational instruction classifier: memory op, finish word, destination register.
module mem_wb_decode
  import mem_wb_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_load,
  output logic        is_store,
  output logic        is_finish,
  output logic        has_dest,
  output logic [4:0]  dest
);

  logic [5:0] op;

  always_comb begin
    op        = instr[31:26];
    is_load   = (op == OP_LW);
    is_store  = (op == OP_SW);
    is_finish = (instr == FINISH_WORD);
    has_dest  = 1'b0;
    dest      = '0;
    if (op == OP_RTYPE) begin
      has_dest = 1'b1;
      dest     = instr[15:11];
    end else if (is_alu_imm(op) || op == OP_LW) begin
      has_dest = 1'b1;
      dest     = instr[20:16];
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage with retire counter and sticky halt.
// Optional dmem_ack timeout enabled by defining MEMWB_TIMEOUT_EN.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       aluoutEX,
  input  logic [31:0]       instructionEX,
  input  logic              ff,
  input  logic [31:0]       store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_en,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data,
  output logic [CNT_W-1:0]  retired,
  output logic              halted,
  output logic              mem_err
);

  state_t     state, state_nx;
  logic       d_load, d_store, d_finish, d_has_dest;
  logic [4:0] d_dest;
  logic       accept, finish, expire;

  mem_wb_decode u_decode (
    .instr     (instructionEX),
    .is_load   (d_load),
    .is_store  (d_store),
    .is_finish (d_finish),
    .has_dest  (d_has_dest),
    .dest      (d_dest)
  );

  assign in_ready = (state == IDLE) || (state == WB);
  assign accept   = in_valid && in_ready;
  assign finish   = ff || d_finish;
  assign dmem_req = (state == MEM);
  assign wb_en    = (state == WB) && (wb_reg != '0);
  assign halted   = (state == HALT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, WB: begin
        if (!accept)                 state_nx = IDLE;
        else if (finish)             state_nx = HALT;
        else if (d_load || d_store)  state_nx = MEM;
        else                         state_nx = WB;
      end
      MEM: begin
        if (dmem_ack)    state_nx = dmem_we ? IDLE : WB;
        else if (expire) state_nx = IDLE;
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_reg     <= '0;
      wb_data    <= '0;
      retired    <= '0;
    end else begin
      if (accept && !finish) begin
        if (d_load || d_store) begin
          dmem_addr  <= aluoutEX[ADDR_W+1:2];
          dmem_we    <= d_store;
          dmem_wdata <= store_data;
        end else begin
          wb_data <= aluoutEX;
        end
        // wb_reg of zero doubles as "no register write" for the WB cycle
        wb_reg <= d_has_dest ? d_dest : 5'd0;
      end
      if (state == MEM && dmem_ack && !dmem_we) wb_data <= dmem_rdata;
      if ((state == WB) || (state == MEM && dmem_ack && dmem_we))
        retired <= retired + CNT_W'(1);
    end
  end

`ifdef MEMWB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          mem_err_q;

  assign expire  = (state == MEM) && !dmem_ack && (tcnt == TW'(TIMEOUT - 1));
  assign mem_err = mem_err_q;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      tcnt      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= expire;
      tcnt      <= (state == MEM) ? tcnt + TW'(1) : '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire  = 1'b0;
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (CNT_W=4 to reach counter wrap quickly).
module tb_mem_wb_stage;

  logic        CLOCK, RESET_N;
  logic        in_valid, in_ready, ff;
  logic [31:0] aluoutEX, instructionEX, store_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [3:0]  retired;
  logic        halted, mem_err;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] ADDU_R5  = 32'h0022_2821;
  localparam logic [31:0] LW_R9    = 32'h8C09_0010;
  localparam logic [31:0] SW_R3    = 32'hAC03_0008;
  localparam logic [31:0] ADDI_R4  = 32'h2004_0003;
  localparam logic [31:0] ORI_R6   = 32'h3406_00FF;
  localparam logic [31:0] BEQ      = 32'h1000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] FINISH   = 32'hFFFF_FFFF;

  mem_wb_stage #(.ADDR_W(10), .CNT_W(4), .TIMEOUT(4)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(in_ready),
    .aluoutEX(aluoutEX), .instructionEX(instructionEX), .ff(ff), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .retired(retired), .halted(halted), .mem_err(mem_err)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                       input logic [31:0] sd, input logic f);
    in_valid = v; instructionEX = ins; aluoutEX = alu; store_data = sd; ff = f;
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESET_N = 1'b0;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if ({dmem_req, dmem_we, wb_en, halted, mem_err} !== 5'b0) begin n_err++;
      $display("FAIL reset_flags got %b want 00000", {dmem_req, dmem_we, wb_en, halted, mem_err}); end
    n_cmp++; if ({retired, dmem_addr, wb_reg, wb_data} !== '0) begin n_err++;
      $display("FAIL reset_values got ret=%0d addr=%0d reg=%0d data=%h want 0", retired, dmem_addr, wb_reg, wb_data); end
    @(negedge CLOCK);
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive(1'b1, ADDU_R5, 32'h7, 32'h0, 1'b0);
    tick();
    drive(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    n_cmp++; if ({wb_en, wb_reg, wb_data} !== {1'b1, 5'd5, 32'h7}) begin n_err++;
      $display("FAIL alu_wb got en=%b reg=%0d data=%h want en=1 reg=5 data=7", wb_en, wb_reg, wb_data); end
    tick();
    n_cmp++; if (retired !== 4'd1 || wb_en !== 1'b0) begin n_err++;
      $display("FAIL alu_retire got ret=%0d en=%b want ret=1 en=0", retired, wb_en); end
  endtask

  task automatic test_load();
    drive(1'b1, LW_R9, 32'h10, 32'h0, 1'b0);
    tick();
    // in_valid held high during MEM must be ignored
    drive(1'b1, ADDU_R5, 32'h99, 32'h0, 1'b0);
    n_cmp++; if ({dmem_req, dmem_we, dmem_addr, in_ready} !== {1'b1, 1'b0, 10'd4, 1'b0}) begin n_err++;
      $display("FAIL lw_req got req=%b we=%b addr=%0d rdy=%b want 1 0 4 0", dmem_req, dmem_we, dmem_addr, in_ready); end
    tick();
    tick();
    n_cmp++; if (dmem_req !== 1'b1 || dmem_addr !== 10'd4 || wb_en !== 1'b0) begin n_err++;
      $display("FAIL lw_hold got req=%b addr=%0d en=%b want 1 4 0", dmem_req, dmem_addr, wb_en); end
    drive(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    n_cmp++; if ({dmem_req, wb_en, wb_reg, wb_data} !== {1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF}) begin n_err++;
      $display("FAIL lw_wb got req=%b en=%b reg=%0d data=%h want 0 1 9 deadbeef", dmem_req, wb_en, wb_reg, wb_data); end
    tick();
    n_cmp++; if (retired !== 4'd2) begin n_err++; $display("FAIL lw_retire got %0d want 2", retired); end
  endtask

  task automatic test_store();
    drive(1'b1, SW_R3, 32'h8, 32'h55, 1'b0);
    tick();
    drive(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    n_cmp++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 10'd2, 32'h55}) begin n_err++;
      $display("FAIL sw_req got req=%b we=%b addr=%0d wdata=%h want 1 1 2 55", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_ack = 1'b0;
    n_cmp++; if ({dmem_req, wb_en, in_ready, retired} !== {1'b0, 1'b0, 1'b1, 4'd3}) begin n_err++;
      $display("FAIL sw_done got req=%b en=%b rdy=%b ret=%0d want 0 0 1 3", dmem_req, wb_en, in_ready, retired); end
    n_cmp++; if (wb_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sw_no_capture got %h want deadbeef", wb_data); end
    // stray ack while idle
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    n_cmp++; if ({dmem_req, wb_en, retired} !== {1'b0, 1'b0, 4'd3}) begin n_err++;
      $display("FAIL idle_ack got req=%b en=%b ret=%0d want 0 0 3", dmem_req, wb_en, retired); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, ADDI_R4, 32'h11, 32'h0, 1'b0);
    tick();
    drive(1'b1, ORI_R6, 32'h22, 32'h0, 1'b0);
    n_cmp++; if ({wb_en, wb_reg, wb_data, in_ready} !== {1'b1, 5'd4, 32'h11, 1'b1}) begin n_err++;
      $display("FAIL b2b_addi got en=%b reg=%0d data=%h rdy=%b want 1 4 11 1", wb_en, wb_reg, wb_data, in_ready); end
    tick();
    drive(1'b1, BEQ, 32'h33, 32'h0, 1'b0);
    n_cmp++; if ({wb_en, wb_reg, wb_data, retired} !== {1'b1, 5'd6, 32'h22, 4'd4}) begin n_err++;
      $display("FAIL b2b_ori got en=%b reg=%0d data=%h ret=%0d want 1 6 22 4", wb_en, wb_reg, wb_data, retired); end
    tick();
    drive(1'b1, NOP, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (wb_en !== 1'b0 || retired !== 4'd5) begin n_err++;
      $display("FAIL b2b_beq got en=%b ret=%0d want 0 5", wb_en, retired); end
    tick();
    drive(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (wb_en !== 1'b0 || retired !== 4'd6) begin n_err++;
      $display("FAIL b2b_nop got en=%b ret=%0d want 0 6", wb_en, retired); end
    tick();
    n_cmp++; if (retired !== 4'd7) begin n_err++; $display("FAIL b2b_retire got %0d want 7", retired); end
  endtask

  task automatic test_wrap();
    drive(1'b1, NOP, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    n_cmp++; if (retired !== 4'd15) begin n_err++; $display("FAIL wrap_max got %0d want 15", retired); end
    drive(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    tick();
    n_cmp++; if (retired !== 4'd0) begin n_err++; $display("FAIL wrap_zero got %0d want 0", retired); end
  endtask

  task automatic test_finish();
    drive(1'b1, ADDU_R5, 32'h7, 32'h0, 1'b0);
    tick();
    drive(1'b1, ADDI_R4, 32'h99, 32'h0, 1'b0);
    tick();
    n_cmp++; if ({wb_en, wb_reg, wb_data} !== {1'b1, 5'd4, 32'h99}) begin n_err++;
      $display("FAIL fin_second_wb got en=%b reg=%0d data=%h want 1 4 99", wb_en, wb_reg, wb_data); end
    drive(1'b1, FINISH, 32'h0, 32'h0, 1'b0);
    tick();
    drive(1'b1, ADDU_R5, 32'h1, 32'h0, 1'b0);
    n_cmp++; if ({halted, in_ready, wb_en, retired} !== {1'b1, 1'b0, 1'b0, 4'd2}) begin n_err++;
      $display("FAIL fin_halt got h=%b rdy=%b en=%b ret=%0d want 1 0 0 2", halted, in_ready, wb_en, retired); end
    tick(); tick(); tick();
    drive(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    n_cmp++; if ({halted, in_ready, wb_en, retired} !== {1'b1, 1'b0, 1'b0, 4'd2}) begin n_err++;
      $display("FAIL fin_sticky got h=%b rdy=%b en=%b ret=%0d want 1 0 0 2", halted, in_ready, wb_en, retired); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    drive(1'b1, SW_R3, 32'h8, 32'h55, 1'b0);
    tick();
    drive(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    tick();
    RESET_N = 1'b0;
    #1;
    n_cmp++; if ({dmem_req, retired, halted} !== {1'b0, 4'd0, 1'b0}) begin n_err++;
      $display("FAIL rst_mid_mem got req=%b ret=%0d h=%b want 0 0 0", dmem_req, retired, halted); end
    @(negedge CLOCK);
    RESET_N = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || dmem_req !== 1'b0) begin n_err++;
      $display("FAIL rst_release got rdy=%b req=%b want 1 0", in_ready, dmem_req); end
  endtask

  task automatic test_ff_flag();
    drive(1'b1, ADDU_R5, 32'h7, 32'h0, 1'b1);
    tick();
    drive(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    n_cmp++; if ({halted, wb_en, in_ready} !== {1'b1, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL ff_halt got h=%b en=%b rdy=%b want 1 0 0", halted, wb_en, in_ready); end
    tick();
    n_cmp++; if (retired !== 4'd0) begin n_err++; $display("FAIL ff_no_retire got %0d want 0", retired); end
  endtask

`ifdef MEMWB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    drive(1'b1, LW_R9, 32'h10, 32'h0, 1'b0);
    tick();
    drive(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    tick(); tick(); tick();
    n_cmp++; if (dmem_req !== 1'b1 || mem_err !== 1'b0) begin n_err++;
      $display("FAIL to_wait got req=%b err=%b want 1 0", dmem_req, mem_err); end
    tick();
    n_cmp++; if ({mem_err, dmem_req, wb_en, in_ready} !== 4'b1001) begin n_err++;
      $display("FAIL to_expire got err=%b req=%b en=%b rdy=%b want 1 0 0 1", mem_err, dmem_req, wb_en, in_ready); end
    tick();
    n_cmp++; if (mem_err !== 1'b0 || retired !== 4'd0) begin n_err++;
      $display("FAIL to_after got err=%b ret=%0d want 0 0", mem_err, retired); end
    drive(1'b1, LW_R9, 32'h10, 32'h0, 1'b0);
    tick();
    drive(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    tick(); tick(); tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_0001;
    tick();
    dmem_ack = 1'b0;
    n_cmp++; if ({mem_err, wb_en, wb_data} !== {1'b0, 1'b1, 32'hCAFE_0001}) begin n_err++;
      $display("FAIL to_ack_wins got err=%b en=%b data=%h want 0 1 cafe0001", mem_err, wb_en, wb_data); end
  endtask
`endif

  initial begin
    drive(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_wrap();
    test_finish();
    test_reset_mid_mem();
    test_ff_flag();
`ifdef MEMWB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
